// File: rtl/mips32_pkg.sv
// Shared constants and next-pc selector encoding for the fetch program counter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0180;
    localparam int INSTR_BYTES = 4;

    // Source of the next fetch address, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_MISALIGN,
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_RAS,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a full push overwrites the oldest entry.
// Latency: push/pop take effect on the clock edge; top is readable combinationally.
// Backpressure: none; a push+pop in one cycle replaces the top, and a pop while empty is ignored.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_dat,
    output logic [XLEN-1:0] top_dat,
    output logic            empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   top;
    logic [CW-1:0]   count;
    logic            pop_ok;

    assign empty   = (count == '0);
    assign top_dat = mem[top];
    assign pop_ok  = pop && !empty;

    // Top pointer and occupancy. The pointer wraps, so a push when full lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            top   <= '0;
            count <= '0;
        end else if (push && pop_ok) begin
            top   <= top;
            count <= count;
        end else if (push) begin
            top   <= top + 1'b1;
            count <= (count == FULL_CNT) ? count : count + 1'b1;
        end else if (pop_ok) begin
            top   <= top - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Entry storage: push+pop rewrites the current top, a plain push writes the slot above it.
    always_ff @(posedge clk) begin
        if (push && pop_ok) begin
            mem[top] <= push_dat;
        end else if (push) begin
            mem[top + 1'b1] <= push_dat;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with priority for exception, redirect, stall and sequential advance. Optional PC_RAS_EN adds a return-address stack.
// Latency: every event shows on pc one cycle after the edge that samples it. The first edge after reset only raises pc_valid.
// Backpressure: stall holds pc. Exception and redirect still override stall.
module pc_unit #(
    parameter int XLEN = mips32_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = mips32_pkg::RESET_VECTOR,
    parameter logic [XLEN-1:0] EXC_VECTOR   = mips32_pkg::EXC_VECTOR,
`ifdef PC_RAS_EN
    parameter int INSTR_BYTES = mips32_pkg::INSTR_BYTES,
    parameter int RAS_DEPTH   = 4
`else
    parameter int INSTR_BYTES = mips32_pkg::INSTR_BYTES
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            exc_valid,
`ifdef PC_RAS_EN
    input  logic            call_push,
    input  logic            ret_pop,
    output logic            ras_miss,
`endif
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_next_seq,
    output logic [XLEN-1:0] epc,
    output logic            misalign_err
);

    import mips32_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    pc_sel_e         sel;
    logic [XLEN-1:0] pc_d;
    logic            misaligned;

    assign pc_next_seq = pc + XLEN'(INSTR_BYTES);
    assign misaligned  = (redirect_target & ALIGN_MASK) != '0;

`ifdef PC_RAS_EN
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_push;
    logic            ras_pop;

    // The call retires even when exception or redirect wins the pc. Only stall suppresses it.
    assign ras_push = pc_valid && call_push && !stall;
    assign ras_pop  = pc_valid && (sel == SEL_RAS);

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_dat (pc_next_seq),
        .top_dat  (ras_top),
        .empty    (ras_empty)
    );
`endif

    // Fixed-priority choice of the next fetch address source.
    always_comb begin
        sel = SEL_SEQ;
        if (exc_valid) begin
            sel = SEL_EXC;
        end else if (redirect_valid && misaligned) begin
            sel = SEL_MISALIGN;
        end else if (redirect_valid) begin
            sel = SEL_REDIRECT;
        end else if (stall) begin
            sel = SEL_HOLD;
`ifdef PC_RAS_EN
        end else if (ret_pop && !ras_empty) begin
            sel = SEL_RAS;
`endif
        end
    end

    // Next-pc mux driven by the selected source.
    always_comb begin
        pc_d = pc_next_seq;
        case (sel)
            SEL_EXC, SEL_MISALIGN: pc_d = EXC_VECTOR;
            SEL_REDIRECT:          pc_d = redirect_target;
            SEL_HOLD:              pc_d = pc;
`ifdef PC_RAS_EN
            SEL_RAS:               pc_d = ras_top;
`endif
            default:               pc_d = pc_next_seq;
        endcase
    end

    // Architectural state. The edge after reset only validates pc, so RESET_VECTOR is fetched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            epc          <= '0;
            misalign_err <= 1'b0;
        end else if (!pc_valid) begin
            pc_valid     <= 1'b1;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_d;
            misalign_err <= (sel == SEL_MISALIGN);
            if (sel == SEL_EXC || sel == SEL_MISALIGN) begin
                epc <= pc;
            end
        end
    end

`ifdef PC_RAS_EN
    // A return predicted with an empty stack falls back to the sequential pc and flags a miss.
    always_ff @(posedge clk) begin
        if (rst || !pc_valid) begin
            ras_miss <= 1'b0;
        end else begin
            ras_miss <= (sel == SEL_SEQ) && ret_pop;
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, sequential advance, stall, redirect, misalignment, exception, wrap, and the optional RAS.
// Latency: each step drives inputs, waits for one rising edge, then samples outputs 1 ns later.
// Backpressure: stall is driven as a directed input.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        exc_valid = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] pc_next_seq;
    logic [31:0] epc;
    logic        misalign_err;
`ifdef PC_RAS_EN
    logic        call_push = 1'b0;
    logic        ret_pop = 1'b0;
    logic        ras_miss;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
`ifdef PC_RAS_EN
        .call_push       (call_push),
        .ret_pop         (ret_pop),
        .ras_miss        (ras_miss),
`endif
        .pc              (pc),
        .pc_valid        (pc_valid),
        .pc_next_seq     (pc_next_seq),
        .epc             (epc),
        .misalign_err    (misalign_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset for three cycles, then release and advance sequentially.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_mis", {31'b0, misalign_err}, 32'h0);
        rst = 1'b0;
        step();
        check("rel_valid", {31'b0, pc_valid}, 32'h1);
        check("rel_pc", pc, 32'h0);
        step(); check("seq_4", pc, 32'h4);
        step(); check("seq_8", pc, 32'h8);
        step(); check("seq_c", pc, 32'hC);
        check("next_seq_c", pc_next_seq, 32'h10);
        step(); check("seq_10", pc, 32'h10);

        // 2: stall holds pc, then release advances it.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_hold", pc, 32'h10);
        end
        stall = 1'b0;
        step(); check("stall_rel", pc, 32'h14);

        // 3: an aligned redirect beats stall, then a misaligned redirect vectors to the exception address.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h400;
        step(); check("redir_over_stall", pc, 32'h400);
        redirect_target = 32'h402;
        step();
        check("mis_pc", pc, 32'h8000_0180);
        check("mis_epc", epc, 32'h400);
        check("mis_pulse", {31'b0, misalign_err}, 32'h1);
        stall = 1'b0; redirect_valid = 1'b0;
        step();
        check("mis_pulse_end", {31'b0, misalign_err}, 32'h0);
        check("after_exc_seq", pc, 32'h8000_0184);

        // 4: exception beats a redirect on the same edge, even a misaligned one.
        redirect_valid = 1'b1; redirect_target = 32'h20;
        step(); check("redir_20", pc, 32'h20);
        exc_valid = 1'b1; redirect_target = 32'h42;
        step();
        check("exc_pc", pc, 32'h8000_0180);
        check("exc_epc", epc, 32'h20);
        check("exc_no_mis", {31'b0, misalign_err}, 32'h0);
        exc_valid = 1'b0;

        // 5: the pc wraps from the top of the address space without raising an error.
        redirect_target = 32'hFFFF_FFFC;
        step();
        check("top_pc", pc, 32'hFFFF_FFFC);
        check("top_next_seq", pc_next_seq, 32'h0);
        redirect_valid = 1'b0;
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_no_mis", {31'b0, misalign_err}, 32'h0);

        // A reset in mid-operation discards the pending exception, which is also ignored on the validating edge.
        rst = 1'b1; exc_valid = 1'b1;
        step();
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_valid", {31'b0, pc_valid}, 32'h0);
        check("mid_rst_epc", epc, 32'h0);
        rst = 1'b0;
        step();
        check("ign_valid", {31'b0, pc_valid}, 32'h1);
        check("ign_pc", pc, 32'h0);
        exc_valid = 1'b0;
        step(); check("ign_seq", pc, 32'h4);

`ifdef PC_RAS_EN
        // 6: five pushes into four entries, four returns, one miss, then push and pop together.
        redirect_valid = 1'b1; redirect_target = 32'h100;
        step(); check("ras_start", pc, 32'h100);
        redirect_valid = 1'b0; call_push = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("ras_pushed_pc", pc, 32'h114);
        call_push = 1'b0; ret_pop = 1'b1;
        step(); check("pop1", pc, 32'h114);
        step(); check("pop2", pc, 32'h110);
        step(); check("pop3", pc, 32'h10C);
        step(); check("pop4", pc, 32'h108);
        check("no_miss", {31'b0, ras_miss}, 32'h0);
        step();
        check("miss_pc", pc, 32'h10C);
        check("miss_pulse", {31'b0, ras_miss}, 32'h1);
        ret_pop = 1'b0; call_push = 1'b1;
        step(); check("push_one", pc, 32'h110);
        check("miss_end", {31'b0, ras_miss}, 32'h0);
        ret_pop = 1'b1;
        step(); check("pushpop_pc", pc, 32'h110);
        call_push = 1'b0;
        step(); check("replaced_top", pc, 32'h114);
        step();
        check("empty_again", pc, 32'h118);
        check("empty_miss", {31'b0, ras_miss}, 32'h1);
        ret_pop = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
